// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Multi-cycle ops latch their result at start and commit HI/LO when the busy count expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MULT_Start,
    input  logic [2:0]  MULT_Op,
    input  logic [31:0] MULT_A,
    input  logic [31:0] MULT_B,
    output logic        MULT_Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;
    logic [31:0]        tmp_hi_reg;
    logic [31:0]        tmp_lo_reg;
    logic               commit_reg;
    logic               busy_reg;

    // Arithmetic datapath, evaluated on the start-cycle operands only
    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic [31:0] b_mag_safe;
    logic [31:0] b_safe;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;

    assign prod_signed   = $signed({{32{MULT_A[31]}}, MULT_A}) * $signed({{32{MULT_B[31]}}, MULT_B});
    assign prod_unsigned = {32'd0, MULT_A} * {32'd0, MULT_B};

    // Signed divide through magnitudes: 0x80000000 has magnitude 0x80000000 as an
    // unsigned value, so the overflow case 0x80000000 / -1 falls out as 0x80000000.
    assign a_neg      = MULT_A[31];
    assign b_neg      = MULT_B[31];
    assign a_mag      = a_neg ? (32'd0 - MULT_A) : MULT_A;
    assign b_mag      = b_neg ? (32'd0 - MULT_B) : MULT_B;
    assign div_zero   = (MULT_B == 32'd0);
    assign b_mag_safe = div_zero ? 32'd1 : b_mag;
    assign b_safe     = div_zero ? 32'd1 : MULT_B;
    assign mag_q      = a_mag / b_mag_safe;
    assign mag_r      = a_mag % b_mag_safe;
    assign sdiv_q     = (a_neg ^ b_neg) ? (32'd0 - mag_q) : mag_q;
    assign sdiv_r     = a_neg ? (32'd0 - mag_r) : mag_r;
    assign udiv_q     = MULT_A / b_safe;
    assign udiv_r     = MULT_A % b_safe;

    logic             launch;
    logic [31:0]      tmp_hi_next;
    logic [31:0]      tmp_lo_next;
    logic             commit_next;
    logic [CNT_W-1:0] cnt_next;

    assign launch = MULT_Start && (MULT_Op >= OP_MULT) && (MULT_Op <= OP_DIVU);

    always_comb begin
        tmp_hi_next = 32'd0;
        tmp_lo_next = 32'd0;
        commit_next = 1'b1;
        cnt_next    = CNT_W'(MULT_CYCLES);
        case (MULT_Op)
            OP_MULT: begin
                tmp_hi_next = prod_signed[63:32];
                tmp_lo_next = prod_signed[31:0];
            end
            OP_MULTU: begin
                tmp_hi_next = prod_unsigned[63:32];
                tmp_lo_next = prod_unsigned[31:0];
            end
            OP_DIV: begin
                tmp_hi_next = sdiv_r;
                tmp_lo_next = sdiv_q;
                commit_next = !div_zero;
                cnt_next    = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                tmp_hi_next = udiv_r;
                tmp_lo_next = udiv_q;
                commit_next = !div_zero;
                cnt_next    = CNT_W'(DIV_CYCLES);
            end
            default: begin
                tmp_hi_next = 32'd0;
                tmp_lo_next = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            tmp_hi_reg <= 32'd0;
            tmp_lo_reg <= 32'd0;
            commit_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        tmp_hi_reg <= tmp_hi_next;
                        tmp_lo_reg <= tmp_lo_next;
                        commit_reg <= commit_next;
                        cnt_reg    <= cnt_next;
                        state_reg  <= BUSY;
                        busy_reg   <= 1'b1;
                    end else if (MULT_Op == OP_MTHI) begin
                        hi_reg <= MULT_A;
                    end else if (MULT_Op == OP_MTLO) begin
                        lo_reg <= MULT_A;
                    end
                end
                BUSY: begin
                    // Inputs are ignored here; the stall controller keeps new ops out.
                    if (cnt_reg == CNT_W'(1)) begin
                        if (commit_reg) begin
                            hi_reg <= tmp_hi_reg;
                            lo_reg <= tmp_lo_reg;
                        end
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign MULT_Busy = busy_reg;
    assign HI        = hi_reg;
    assign LO        = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised scoreboard bench for mult_div_unit: the driver predicts per-cycle
// HI/LO/Busy from plain arithmetic, a negedge monitor pops and compares.
module tb_mult_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        MULT_Start;
    logic [2:0]  MULT_Op;
    logic [31:0] MULT_A;
    logic [31:0] MULT_B;
    logic        MULT_Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MULT_Start(MULT_Start),
        .MULT_Op   (MULT_Op),
        .MULT_A    (MULT_A),
        .MULT_B    (MULT_B),
        .MULT_Busy (MULT_Busy),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
    } item_t;

    item_t sb_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic void push(int due, logic [31:0] hi, logic [31:0] lo, logic busy);
        item_t it;
        it.due  = due;
        it.hi   = hi;
        it.lo   = lo;
        it.busy = busy;
        sb_q.push_back(it);
    endfunction

    // Monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            item_t it;
            it = sb_q.pop_front();
            if (it.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expectation cyc=%0d actual_due=%0d required_due=%0d", cyc, it.due, cyc);
            end else begin
                chk("busy", {31'd0, MULT_Busy}, {31'd0, it.busy});
                chk("hi", HI, it.hi);
                chk("lo", LO, it.lo);
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Drive one operation in cycle k; abort_at>0 asserts reset in that busy cycle.
    task automatic issue(input logic [2:0] op, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input int abort_at);
        logic [31:0] nhi;
        logic [31:0] nlo;
        logic [63:0] pu;
        longint      ps;
        longint      sa;
        longint      sbv;
        int          n;
        int          k;
        @(posedge clk);
        #1;
        k = cyc;
        MULT_Op    = op;
        MULT_Start = st;
        MULT_A     = a;
        MULT_B     = b;
        push(k, model_hi, model_lo, 1'b0);
        nhi = model_hi;
        nlo = model_lo;
        if (st && op >= 3'd1 && op <= 3'd4) begin
            n = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
            case (op)
                3'd1: begin
                    ps = longint'($signed(a)) * longint'($signed(b));
                    {nhi, nlo} = ps;
                end
                3'd2: begin
                    pu = {32'd0, a} * {32'd0, b};
                    {nhi, nlo} = pu;
                end
                3'd3: if (b != 32'd0) begin
                    sa  = longint'($signed(a));
                    sbv = longint'($signed(b));
                    ps  = sa / sbv;
                    nlo = ps[31:0];
                    ps  = sa % sbv;
                    nhi = ps[31:0];
                end
                default: if (b != 32'd0) begin
                    nlo = a / b;
                    nhi = a % b;
                end
            endcase
            for (int j = 1; j <= n; j++) begin
                @(posedge clk);
                #1;
                if (abort_at != 0 && j >= abort_at) begin
                    reset      = (j == abort_at);
                    MULT_Op    = 3'd0;
                    MULT_Start = 1'b0;
                end else begin
                    MULT_Op    = 3'($urandom_range(0, 7));
                    MULT_Start = 1'($urandom_range(0, 1));
                    MULT_A     = $urandom;
                    MULT_B     = pick_operand();
                end
                if (abort_at != 0 && j > abort_at)
                    push(k + j, 32'd0, 32'd0, 1'b0);
                else
                    push(k + j, model_hi, model_lo, 1'b1);
            end
            if (abort_at != 0) begin
                model_hi = 32'd0;
                model_lo = 32'd0;
            end else begin
                model_hi = nhi;
                model_lo = nlo;
            end
            push(k + n + 1, model_hi, model_lo, 1'b0);
        end else if (op == 3'd5 || op == 3'd6) begin
            if (op == 3'd5) model_hi = a;
            else            model_lo = a;
            push(k + 1, model_hi, model_lo, 1'b0);
        end
    endtask

    initial begin
        logic [2:0] rop;
        logic       rst;
        reset      = 1'b1;
        MULT_Start = 1'b0;
        MULT_Op    = 3'd0;
        MULT_A     = 32'd0;
        MULT_B     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push(cyc, 32'd0, 32'd0, 1'b0);

        issue(3'd5, 1'b0, 32'h1234_5678, 32'd0, 0);
        issue(3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3, 0);
        issue(3'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(3'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd5, 1'b0, 32'h0000_00AA, 32'd0, 0);
        issue(3'd6, 1'b0, 32'h0000_00BB, 32'd0, 0);
        issue(3'd3, 1'b1, 32'h0000_1234, 32'd0, 0);
        issue(3'd4, 1'b1, 32'h0000_0005, 32'd0, 0);
        issue(3'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(3'd7, 1'b1, 32'h5555_5555, 32'd9, 0);
        issue(3'd0, 1'b1, 32'h6666_6666, 32'd9, 0);
        issue(3'd6, 1'b1, 32'hCAFE_F00D, 32'd0, 0);
        issue(3'd1, 1'b1, 32'h0000_0007, 32'h0000_0009, 3);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rst = (rop >= 3'd1 && rop <= 3'd4) ? ($urandom_range(0, 3) != 0)
                                                : 1'($urandom_range(0, 1));
            issue(rop, rst, pick_operand(), pick_operand(), 0);
        end

        @(posedge clk);
        #1;
        MULT_Op    = 3'd0;
        MULT_Start = 1'b0;
        repeat (DIV_CYCLES + 4) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual_pending=%0d required_pending=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
